id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Parametrised successor to the ID/EX pipeline latch. Registers decode-stage operands, register addresses and control bundle into EX.
- Adds a valid/ready handshake, a 2-entry skid buffer (in_ready has no combinational path from out_ready), global freeze (le) and flush (clear) that inserts a bubble.
- Sits between the decode/hazard unit and the EX stage of the MIPS core.

Parameters:
- DATA_W, 32, width of rdata1, rdata2 and the extended immediate.
- REG_AW, 5, register-address width for rs/rt/rd.
- CTRL_W, 11, control bundle width: ALUControl[5:0], ALUSrc, RegWrite, MemtoReg, MemWrite, RegDst (bit layout from package).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- le  in  1  stage enable; 0 freezes state, in_ready=0, out_valid=0.
- clear  in  1  flush; empties both entries next edge.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage can accept.
- in_rdata1, in_rdata2, in_imm  in  DATA_W each  operands / extended immediate.
- in_rs, in_rt, in_rd  in  REG_AW each  register addresses.
- in_ctrl  in  CTRL_W  control bundle.
- out_valid  out  1  EX holds a valid instruction.
- out_ready  in  1  EX accepts.
- out_rdata1, out_rdata2, out_imm  out  DATA_W each.
- out_rs, out_rt, out_rd  out  REG_AW each.
- out_ctrl  out  CTRL_W.

Behaviour:
- Reset is synchronous and active-low on rst_n; single clock clk.
- Storage: main entry drives out_* and a skid entry. State is EMPTY, ONE or FULL, registered.
- accept = le & in_valid & in_ready. drain = le & out_valid & out_ready.
- in_ready = le & (state != FULL). out_valid = le & (state != EMPTY). Both are decoded from registers only.
- EMPTY: accept -> ONE, main<=in.
- ONE, accept & drain: stay ONE, main<=in.
- ONE, accept & !drain: -> FULL, skid<=in.
- ONE, drain & !accept: -> EMPTY.
- FULL: no accept possible. drain -> ONE, main<=skid.
- Latency: 1 cycle from accept into EMPTY/ONE-with-drain to out_valid. Throughput is 1 per cycle with out_ready held high.
- Priority: rst_n low > clear > le=0 hold > normal transitions.
- clear: state->EMPTY, both entries invalidated. Any same-cycle accept/drain is discarded (the upstream handshake still completes; the instruction is squashed).
- le=0 with clear=1: flush still happens.
- Bubble safety: when state==EMPTY, out_ctrl is forced to 0 (RegWrite, MemWrite, MemtoReg = 0). Data/address outputs hold their last value.
- Reset: state EMPTY; main, skid and all out_* = 0; in_ready=0 during reset cycle, then follows the equations above.
- Reset mid-transfer: all in-flight entries lost; no partial update.
- No ordering reversal: the skid entry is always older than any new accept.

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined: adds output stall_cnt (16 bits) and parameter CNT_W=16. stall_cnt increments, saturating at all-ones, on cycles with le & in_valid & !in_ready. Cleared only by rst_n; unaffected by clear.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: CTRL_W, bit-index constants (CTRL_ALUOP_LSB=0, CTRL_ALUSRC=6, CTRL_REGWRITE=7, CTRL_MEMTOREG=8, CTRL_MEMWRITE=9, CTRL_REGDST=10), state encoding typedef (EMPTY=0, ONE=1, FULL=2).
- One natural sub-module: pipe_skid_entry. It is a width-generic payload register with load enable and synchronous clear, instantiated twice (main, skid) with payload = {rdata1, rdata2, imm, rs, rt, rd, ctrl}.

Test Plan:
- Reset: rst_n=0 two cycles with in_valid=1 -> out_valid=0, out_ctrl=0, all out_* 0; in_ready=1 on the first cycle after release with le=1.
- Streaming: out_ready=1, 8 back-to-back instructions with rdata1=1..8 -> out_rdata1 shows 1..8 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
- Backpressure: out_ready=0 after instr A accepted, present B, C -> B lands in skid, in_ready=0, C held. Raise out_ready -> A, B, C emerge in order, no loss/duplication.
- Flush: FULL with A, B, assert clear with in_valid=1 (D) -> next cycle out_valid=0, out_ctrl=0, state EMPTY, D not output.
- Freeze: le=0 for 3 cycles while ONE -> in_ready=0, out_valid=0, payload unchanged. le=1 -> same instruction presented.
- With ID_EX_PERF_CNT_EN: hold FULL with in_valid=1 for 5 cycles -> stall_cnt=5. Apply clear -> stall_cnt stays 5.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle layout and occupancy state encoding.
package id_ex_stage_pkg;

   localparam int CTRL_W         = 11;
   localparam int CTRL_ALUOP_LSB = 0;
   localparam int CTRL_ALUSRC    = 6;
   localparam int CTRL_REGWRITE  = 7;
   localparam int CTRL_MEMTOREG  = 8;
   localparam int CTRL_MEMWRITE  = 9;
   localparam int CTRL_REGDST    = 10;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

endpackage

// File: rtl/id_ex_stage_skid_entry.sv
// Width-generic payload register with load enable and synchronous clear (clear wins).
module pipe_skid_entry #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage with valid/ready handshake, 2-entry skid buffer, freeze (le) and flush (clear).
// Optional stall counter output enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
`ifdef ID_EX_PERF_CNT_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              le,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_rdata1,
   input  logic [DATA_W-1:0] in_rdata2,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [REG_AW-1:0] in_rs,
   input  logic [REG_AW-1:0] in_rt,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rdata1,
   output logic [DATA_W-1:0] out_rdata2,
   output logic [DATA_W-1:0] out_imm,
   output logic [REG_AW-1:0] out_rs,
   output logic [REG_AW-1:0] out_rt,
   output logic [REG_AW-1:0] out_rd,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   localparam int PW = 3*DATA_W + 3*REG_AW + CTRL_W;

   stage_state_t state_reg, state_next;

   logic [PW-1:0]     in_payload, main_d, main_q, skid_q;
   logic [CTRL_W-1:0] main_ctrl;
   logic              accept, drain;
   logic              main_load, skid_load, main_from_skid;

   // Handshake flags depend only on state, le and reset: never on out_ready.
   assign in_ready  = rst_n & le & (state_reg != FULL);
   assign out_valid = rst_n & le & (state_reg != EMPTY);
   assign accept    = le & in_valid & in_ready;
   assign drain     = le & out_valid & out_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_reg <= EMPTY;
      else
         state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      if (clear) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: if (accept) state_next = ONE;
            ONE: begin
               if (accept && !drain)
                  state_next = FULL;
               else if (drain && !accept)
                  state_next = EMPTY;
            end
            FULL:    if (drain) state_next = ONE;
            default: state_next = EMPTY;
         endcase
      end
   end

   // Output / datapath control; a flush suppresses every load.
   always_comb begin
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      if (!clear) begin
         case (state_reg)
            EMPTY: main_load = accept;
            ONE: begin
               main_load = accept & drain;
               skid_load = accept & ~drain;
            end
            FULL: begin
               main_load      = drain;
               main_from_skid = drain;
            end
            default: ;
         endcase
      end
   end

   assign in_payload = {in_rdata1, in_rdata2, in_imm, in_rs, in_rt, in_rd, in_ctrl};
   assign main_d     = main_from_skid ? skid_q : in_payload;

   pipe_skid_entry #(.W(PW)) u_main (
      .clk  (clk),
      .clr  (~rst_n),
      .load (main_load),
      .d    (main_d),
      .q    (main_q)
   );

   pipe_skid_entry #(.W(PW)) u_skid (
      .clk  (clk),
      .clr  (~rst_n),
      .load (skid_load),
      .d    (in_payload),
      .q    (skid_q)
   );

   assign {out_rdata1, out_rdata2, out_imm, out_rs, out_rt, out_rd, main_ctrl} = main_q;
   // An empty stage presents a bubble: no register or memory write can leak into EX.
   assign out_ctrl = (state_reg == EMPTY) ? '0 : main_ctrl;

`ifdef ID_EX_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (le && in_valid && !in_ready && !(&stall_cnt))
         stall_cnt <= stall_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: cycle table with scoreboard-checked payloads, plus reset and stall-counter sequences.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 11;
   localparam int PW = 3*DW + 3*AW + CW;

   logic          clk = 1'b0;
   logic          rst_n, le, clear, in_valid, out_ready;
   logic          in_ready, out_valid;
   logic [DW-1:0] in_rdata1, in_rdata2, in_imm, out_rdata1, out_rdata2, out_imm;
   logic [AW-1:0] in_rs, in_rt, in_rd, out_rs, out_rt, out_rd;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [PW-1:0] in_pl, out_pl;
`ifdef ID_EX_PERF_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   always #5 clk = ~clk;

   assign {in_rdata1, in_rdata2, in_imm, in_rs, in_rt, in_rd, in_ctrl} = in_pl;
   assign out_pl = {out_rdata1, out_rdata2, out_imm, out_rs, out_rt, out_rd, out_ctrl};

   id_ex_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .le         (le),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rdata1  (in_rdata1),
      .in_rdata2  (in_rdata2),
      .in_imm     (in_imm),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_rd      (in_rd),
      .in_ctrl    (in_ctrl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_rdata1 (out_rdata1),
      .out_rdata2 (out_rdata2),
      .out_imm    (out_imm),
      .out_rs     (out_rs),
      .out_rt     (out_rt),
      .out_rd     (out_rd),
      .out_ctrl   (out_ctrl)
`ifdef ID_EX_PERF_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   typedef struct {
      bit v, ordy, le, clr;
      bit exp_ir, exp_ov;
   } row_t;

   row_t          tbl[$];
   logic [PW-1:0] sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            seq   = 1;

   function automatic row_t R(bit v, bit o, bit l, bit c, bit ir, bit ov);
      row_t r;
      r.v = v; r.ordy = o; r.le = l; r.clr = c; r.exp_ir = ir; r.exp_ov = ov;
      return r;
   endfunction

   // Distinct, recognisable payload per instruction number; ctrl always non-zero.
   function automatic logic [PW-1:0] mk(int s);
      return {32'(s), 32'(s*7+3) ^ 32'hA5A5_0000, 32'(s << 4),
              5'(s), 5'(s+1), 5'(s+2), 11'h400 | 11'(s)};
   endfunction

   task automatic chk(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(row_t r, int idx);
      bit acc, drn;
      in_valid  = r.v;
      out_ready = r.ordy;
      le        = r.le;
      clear     = r.clr;
      in_pl     = mk(seq);
      #1;
      chk("in_ready", PW'(in_ready), PW'(r.exp_ir));
      chk("out_valid", PW'(out_valid), PW'(r.exp_ov));
      if (sb.size() > 0)
         chk("payload", out_pl, sb[0]);
      else
         chk("bubble_ctrl", PW'(out_ctrl), '0);
      acc = r.le & r.v & r.exp_ir;
      drn = r.le & r.exp_ov & r.ordy;
      $display("row %0d: v=%0b ordy=%0b le=%0b clr=%0b in_ready=%0b out_valid=%0b out_rdata1=%0d acc=%0b drn=%0b",
               idx, r.v, r.ordy, r.le, r.clr, in_ready, out_valid, out_rdata1, acc, drn);
      if (r.clr) begin
         sb.delete();
      end else begin
         if (drn && sb.size() > 0) void'(sb.pop_front());
         if (acc) sb.push_back(mk(seq));
      end
      if (acc) seq++;
      @(negedge clk);
   endtask

   initial begin
      // Streaming: 8 back-to-back, then drain the last one
      for (int i = 0; i < 8; i++) tbl.push_back(R(1, 1, 1, 0, 1, i > 0));
      tbl.push_back(R(0, 1, 1, 0, 1, 1));
      // Backpressure: A, B into skid, C held, then drain in order
      tbl.push_back(R(1, 0, 1, 0, 1, 0));
      tbl.push_back(R(1, 0, 1, 0, 1, 1));
      tbl.push_back(R(1, 0, 1, 0, 0, 1));
      tbl.push_back(R(1, 0, 1, 0, 0, 1));
      tbl.push_back(R(1, 1, 1, 0, 0, 1));
      tbl.push_back(R(1, 1, 1, 0, 1, 1));
      tbl.push_back(R(0, 1, 1, 0, 1, 1));
      tbl.push_back(R(0, 0, 1, 0, 1, 0));
      // Flush from FULL with D presented, then flush from ONE with accept+drain
      tbl.push_back(R(1, 0, 1, 0, 1, 0));
      tbl.push_back(R(1, 0, 1, 0, 1, 1));
      tbl.push_back(R(1, 1, 1, 1, 0, 1));
      tbl.push_back(R(0, 1, 1, 0, 1, 0));
      tbl.push_back(R(1, 0, 1, 0, 1, 0));
      tbl.push_back(R(1, 1, 1, 1, 1, 1));
      tbl.push_back(R(0, 1, 1, 0, 1, 0));
      // Freeze for 3 cycles while ONE
      tbl.push_back(R(1, 0, 1, 0, 1, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(R(1, 1, 0, 0, 0, 0));
      tbl.push_back(R(0, 1, 1, 0, 1, 1));
      tbl.push_back(R(0, 0, 1, 0, 1, 0));
      // Flush while frozen
      tbl.push_back(R(1, 0, 1, 0, 1, 0));
      tbl.push_back(R(1, 1, 0, 1, 0, 0));
      tbl.push_back(R(0, 0, 1, 0, 1, 0));

      // Reset held two cycles with in_valid=1
      rst_n = 1'b0; le = 1'b1; clear = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_pl = mk(99);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_out_valid", PW'(out_valid), '0);
      chk("rst_in_ready", PW'(in_ready), '0);
      chk("rst_outputs", out_pl, '0);
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      chk("post_rst_in_ready", PW'(in_ready), PW'(1'b1));
      chk("post_rst_out_valid", PW'(out_valid), '0);
      @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

`ifdef ID_EX_PERF_CNT_EN
      rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      #1;
      chk("cnt_after_reset", PW'(stall_cnt), '0);
      @(negedge clk);
      step(R(1, 0, 1, 0, 1, 0), 100);
      step(R(1, 0, 1, 0, 1, 1), 101);
      for (int i = 0; i < 5; i++) step(R(1, 0, 1, 0, 0, 1), 102 + i);
      chk("stall_cnt_5", PW'(stall_cnt), PW'(16'd5));
      step(R(0, 0, 1, 1, 0, 1), 107);
      chk("stall_cnt_after_clear", PW'(stall_cnt), PW'(16'd5));
      step(R(0, 0, 1, 0, 1, 0), 108);
      chk("stall_cnt_hold", PW'(stall_cnt), PW'(16'd5));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
